// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter controller.
package pc_pkg;

  // Controller state; the encoding is exported on state_out for debug.
  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_t;

  // Sequential advance step in bytes.
  localparam int INSTR_BYTES = 4;

  // Only the two low address bits decide alignment, so callers pass just those.
  // Compressed fetch allows halfword-aligned targets; otherwise word alignment.
  function automatic logic is_misaligned(input logic [1:0] addr,
                                         input logic       compressed_en);
    return compressed_en ? addr[0] : (addr != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap > misaligned redirect > redirect > advance > hold.
// Only RUN moves the PC; BOOT and HALT hold it and never flag misalignment.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 64,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR   = 'h100,
  parameter bit                    COMPRESSED_EN = 1'b0
) (
  input  pc_state_t              i_state,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  input  logic                   i_trap,
  input  logic                   i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_target,
  input  logic                   i_ready,
  input  logic                   i_stall,
  output logic [ADDR_WIDTH-1:0]  o_next_pc,
  output logic                   o_misalign_hit
);

  logic w_target_misaligned;

  assign w_target_misaligned = is_misaligned(i_redirect_target[1:0], COMPRESSED_EN);

  // Priority selection of the next fetch address.
  always_comb begin
    // NOTE: every output gets a default first so no path through the ifs can infer a latch.
    o_next_pc      = i_pc;
    o_misalign_hit = 1'b0;
    if (i_state == PC_RUN) begin
      if (i_trap) begin
        o_next_pc = TRAP_VECTOR;
      end else if (i_redirect_valid && w_target_misaligned) begin
        o_next_pc      = TRAP_VECTOR;
        o_misalign_hit = 1'b1;
      end else if (i_redirect_valid) begin
        o_next_pc = i_redirect_target;
      end else if (i_ready && !i_stall) begin
        // Wraps naturally modulo 2^ADDR_WIDTH.
        o_next_pc = i_pc + ADDR_WIDTH'(INSTR_BYTES);
      end
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage program-counter controller: boot cycle, valid/ready handshake,
// stall, trap/redirect with alignment checking, and halt/resume.
// All outputs come straight from registers.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH_POW = 6,
  localparam int                   ADDR_WIDTH     = 1 << ADDR_WIDTH_POW,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR   = 'h1000,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR    = 'h100,
  parameter bit                    COMPRESSED_EN  = 1'b0
) (
  input  logic                  clk_in,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  pc_valid,
  input  logic                  pc_ready,
  input  logic                  stall_in,
  input  logic                  redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0] redirect_target_in,
  input  logic                  trap_in,
  input  logic                  halt_in,
  input  logic                  resume_in,
  output logic                  misalign_err_out,
  output logic [1:0]            state_out
);

  pc_state_t             r_state;
  pc_state_t             w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_pc_valid;
  logic                  r_misalign_err;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic                  w_misalign_hit;

  pc_next_sel #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .TRAP_VECTOR   (TRAP_VECTOR),
    .COMPRESSED_EN (COMPRESSED_EN)
  ) u_next_sel (
    .i_state           (r_state),
    .i_pc              (r_pc),
    .i_trap            (trap_in),
    .i_redirect_valid  (redirect_valid_in),
    .i_redirect_target (redirect_target_in),
    .i_ready           (pc_ready),
    .i_stall           (stall_in),
    .o_next_pc         (w_next_pc),
    .o_misalign_hit    (w_misalign_hit)
  );

  // State transitions; halt beats resume when both are asserted in HALT.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      PC_BOOT: w_state_next = PC_RUN;
      PC_RUN:  w_state_next = halt_in ? PC_HALT : PC_RUN;
      PC_HALT: w_state_next = (!halt_in && resume_in) ? PC_RUN : PC_HALT;
      default: w_state_next = PC_BOOT;
    endcase
  end

  // State, PC, valid flag and error pulse registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state        <= PC_BOOT;
      r_pc           <= RESET_VECTOR;
      r_pc_valid     <= 1'b0;
      r_misalign_err <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_next_pc;
      r_pc_valid     <= (w_state_next == PC_RUN);
      r_misalign_err <= w_misalign_hit;
    end
  end

  assign pc_out           = r_pc;
  assign pc_valid         = r_pc_valid;
  assign misalign_err_out = r_misalign_err;
  assign state_out        = r_state;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: two instances (word-aligned and compressed) share the
// stimulus; a behavioural model of each is compared every cycle, and a
// directed sequence pins the model with literal expectations.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_ready;
  logic        stall_in;
  logic        redirect_valid_in;
  logic [63:0] redirect_target_in;
  logic        trap_in;
  logic        halt_in;
  logic        resume_in;

  logic [63:0] pc0, pc1;
  logic        valid0, valid1;
  logic        err0, err1;
  logic [1:0]  st0, st1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_ctrl #(.COMPRESSED_EN(1'b0)) dut0 (
    .clk_in             (clk),
    .reset              (reset),
    .pc_out             (pc0),
    .pc_valid           (valid0),
    .pc_ready           (pc_ready),
    .stall_in           (stall_in),
    .redirect_valid_in  (redirect_valid_in),
    .redirect_target_in (redirect_target_in),
    .trap_in            (trap_in),
    .halt_in            (halt_in),
    .resume_in          (resume_in),
    .misalign_err_out   (err0),
    .state_out          (st0)
  );

  pc_ctrl #(.COMPRESSED_EN(1'b1)) dut1 (
    .clk_in             (clk),
    .reset              (reset),
    .pc_out             (pc1),
    .pc_valid           (valid1),
    .pc_ready           (pc_ready),
    .stall_in           (stall_in),
    .redirect_valid_in  (redirect_valid_in),
    .redirect_target_in (redirect_target_in),
    .trap_in            (trap_in),
    .halt_in            (halt_in),
    .resume_in          (resume_in),
    .misalign_err_out   (err1),
    .state_out          (st1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: k=0 needs 4-byte targets, k=1 needs 2-byte targets.
  // State numbering 0=boot, 1=run, 2=halt is the documented debug encoding.
  logic [63:0] m_pc [2];
  int          m_st [2];
  logic        m_err[2];
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pc[k]  = 64'h1000;
        m_st[k]  = 0;
        m_err[k] = 1'b0;
      end else begin
        m_err[k] = 1'b0;
        if (m_st[k] == 0) begin
          m_st[k] = 1;
        end else if (m_st[k] == 1) begin
          if (trap_in)
            m_pc[k] = 64'h100;
          else if (redirect_valid_in &&
                   (redirect_target_in % ((k == 1) ? 64'd2 : 64'd4)) != 64'd0) begin
            m_pc[k]  = 64'h100;
            m_err[k] = 1'b1;
          end else if (redirect_valid_in)
            m_pc[k] = redirect_target_in;
          else if (pc_ready && !stall_in)
            m_pc[k] = m_pc[k] + 64'd4;
          if (halt_in) m_st[k] = 2;
        end else begin
          if (!halt_in && resume_in) m_st[k] = 1;
        end
      end
    end
    if (reset) model_live = 1'b1;
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_live) begin
      check("pc0",    pc0,    m_pc[0]);
      check("valid0", 64'(valid0), 64'(m_st[0] == 1));
      check("err0",   64'(err0),   64'(m_err[0]));
      check("state0", 64'(st0),    64'(m_st[0]));
      check("pc1",    pc1,    m_pc[1]);
      check("valid1", 64'(valid1), 64'(m_st[1] == 1));
      check("err1",   64'(err1),   64'(m_err[1]));
      check("state1", 64'(st1),    64'(m_st[1]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic lit(input string tag, input logic [63:0] pc_e, input int st_e, input bit valid_e);
    check({tag, " pc"},    pc0,         pc_e);
    check({tag, " state"}, 64'(st0),    64'(st_e));
    check({tag, " valid"}, 64'(valid0), 64'(valid_e));
  endtask

  initial begin
    reset = 1'b1; pc_ready = 1'b1; stall_in = 1'b0; redirect_valid_in = 1'b0;
    redirect_target_in = '0; trap_in = 1'b0; halt_in = 1'b0; resume_in = 1'b0;
    tick(); tick();
    lit("reset", 64'h1000, 0, 1'b0);
    check("reset err", 64'(err0), 64'd0);

    // Boot then sequential fetch.
    reset = 1'b0;
    tick(); lit("run0", 64'h1000, 1, 1'b1);
    tick(); lit("run1", 64'h1004, 1, 1'b1);
    tick(); lit("run2", 64'h1008, 1, 1'b1);

    // Backpressure, then stall, both hold the PC.
    pc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); lit("notready", 64'h1008, 1, 1'b1); end
    pc_ready = 1'b1; stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); lit("stall", 64'h1008, 1, 1'b1); end
    stall_in = 1'b0;
    tick(); lit("release", 64'h100C, 1, 1'b1);

    // Trap beats redirect; redirect beats stall.
    redirect_valid_in = 1'b1; redirect_target_in = 64'h2000; trap_in = 1'b1;
    tick(); lit("trap", 64'h100, 1, 1'b1);
    check("trap err", 64'(err0), 64'd0);
    trap_in = 1'b0; stall_in = 1'b1;
    tick(); lit("redir stall", 64'h2000, 1, 1'b1);
    stall_in = 1'b0;

    // Halfword target: misaligned for word mode, fine for compressed mode.
    redirect_target_in = 64'h2002;
    tick();
    lit("misalign", 64'h100, 1, 1'b1);
    check("misalign err0", 64'(err0), 64'd1);
    check("compressed pc1", pc1, 64'h2002);
    check("compressed err1", 64'(err1), 64'd0);
    redirect_valid_in = 1'b0; pc_ready = 1'b0;
    tick();
    check("err0 pulse end", 64'(err0), 64'd0);

    // Wrap past the top of the address space.
    redirect_valid_in = 1'b1; redirect_target_in = 64'hFFFF_FFFF_FFFF_FFFC; pc_ready = 1'b1;
    tick(); lit("top", 64'hFFFF_FFFF_FFFF_FFFC, 1, 1'b1);
    redirect_valid_in = 1'b0;
    tick(); lit("wrap", 64'h0, 1, 1'b1);

    // Halt: the selected update still applies, then the PC freezes.
    redirect_valid_in = 1'b1; redirect_target_in = 64'h3000;
    tick(); lit("to3000", 64'h3000, 1, 1'b1);
    redirect_valid_in = 1'b0; halt_in = 1'b1;
    tick(); lit("halt", 64'h3004, 2, 1'b0);
    halt_in = 1'b0; redirect_valid_in = 1'b1; redirect_target_in = 64'h5000; trap_in = 1'b1;
    tick(); lit("halt ignore", 64'h3004, 2, 1'b0);
    redirect_valid_in = 1'b0; trap_in = 1'b0; halt_in = 1'b1; resume_in = 1'b1;
    tick(); lit("halt wins", 64'h3004, 2, 1'b0);
    halt_in = 1'b0; pc_ready = 1'b0;
    tick(); lit("resume", 64'h3004, 1, 1'b1);
    resume_in = 1'b0; halt_in = 1'b1;
    tick(); lit("halt again", 64'h3004, 2, 1'b0);
    halt_in = 1'b0; reset = 1'b1;
    tick(); lit("reset in halt", 64'h1000, 0, 1'b0);
    reset = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset              = ($urandom_range(0, 199) == 0);
      pc_ready           = ($urandom_range(0, 3) != 0);
      stall_in           = ($urandom_range(0, 3) == 0);
      trap_in            = ($urandom_range(0, 15) == 0);
      redirect_valid_in  = ($urandom_range(0, 7) == 0);
      redirect_target_in = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) == 0) redirect_target_in[63:8] = '1;
      halt_in            = ($urandom_range(0, 19) == 0);
      resume_in          = ($urandom_range(0, 3) == 0);
      tick();
    end

    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Parametrised program-counter controller for the fetch stage. It generalises the plain registered PC with:
- a reset vector and a one-cycle boot state
- a valid/ready handshake to fetch
- a stall input
- branch/jump redirect and trap redirect, with fixed priority
- alignment checking of redirect targets
- halt/resume control

It sits between the branch/trap logic and instruction fetch, and supplies the address of the instruction currently being fetched.

Parameters:
- ADDR_WIDTH_POW, 6, log2 of address width (width is always a power of 2).
- ADDR_WIDTH, 1 << ADDR_WIDTH_POW, address width in bits; derived, not overridden.
- RESET_VECTOR, 'h1000, PC value loaded on reset.
- TRAP_VECTOR, 'h100, PC value loaded on trap or misaligned redirect.
- COMPRESSED_EN, 0, 0: targets must be 4-byte aligned; 1: targets must be 2-byte aligned.

Ports:
- clk_in  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_out  out  ADDR_WIDTH  current fetch address.
- pc_valid  out  1  pc_out is a valid fetch request.
- pc_ready  in  1  fetch accepts pc_out this cycle.
- stall_in  in  1  pipeline stall; blocks sequential advance only.
- redirect_valid_in  in  1  branch/jump taken.
- redirect_target_in  in  ADDR_WIDTH  branch/jump target.
- trap_in  in  1  exception/interrupt; go to TRAP_VECTOR.
- halt_in  in  1  request halt.
- resume_in  in  1  leave halt.
- misalign_err_out  out  1  one-cycle pulse: misaligned redirect target detected.
- state_out  out  2  current state encoding (debug).

Behaviour:
Reset and latency:
- Reset, sampled on the clk_in edge, overrides everything. It sets pc_out=RESET_VECTOR, pc_valid=0, misalign_err_out=0, state=BOOT.
- All outputs are registered. A selection made at edge n is visible on pc_out after edge n.
- Reset asserted mid-operation discards any pending redirect, trap or halt. The PC returns to RESET_VECTOR on the next edge.

States:
- BOOT: pc_valid=0; pc held. Transitions to RUN unconditionally on the next edge.
- RUN: pc_valid=1. Next-PC priority, highest first:
  1. trap_in -> TRAP_VECTOR.
  2. redirect_valid_in with misaligned target -> TRAP_VECTOR, and misalign_err_out=1 for the following cycle.
  3. redirect_valid_in with aligned target -> redirect_target_in.
  4. pc_ready && !stall_in -> pc_out + 4.
  5. Otherwise -> hold.
- Misalignment: target[1:0]!=0 when COMPRESSED_EN=0; target[0]!=0 when COMPRESSED_EN=1.
- Trap and redirect override stall_in and do not require pc_ready.
- halt_in in RUN: the PC update selected by the priority above still applies this cycle, then the state moves to HALT.
- HALT: pc_valid=0; pc held. redirect_valid_in, trap_in and stall_in are ignored.
  - resume_in -> RUN with the same pc.
  - If halt_in and resume_in are both high in HALT, halt_in wins and the block stays in HALT.
- In RUN, resume_in is ignored.

Handshake and arithmetic:
- While pc_valid && !pc_ready and no trap or redirect is present, pc_out must stay stable.
- Increment is always 4 and wraps modulo 2^ADDR_WIDTH; no overflow flag.
- misalign_err_out is a single-cycle pulse and is low at all other times.

Invariant:
- In RUN, if the previous cycle had pc_ready=1, stall_in=0, trap_in=0 and redirect_valid_in=0, then pc_out == $past(pc_out)+4.

Decomposition:
- Package pc_pkg:
  - pc_state_t enum: PC_BOOT=2'd0, PC_RUN=2'd1, PC_HALT=2'd2.
  - localparam INSTR_BYTES=4.
  - function is_misaligned(addr, compressed_en).
- Sub-module pc_next_sel: combinational priority mux producing next_pc and misalign_hit from the current pc and the control inputs.
- pc_ctrl holds the state register, the pc register and the error pulse register.

Test Plan:
- Reset release, pc_ready=1: cycle 0 BOOT, pc_valid=0, pc_out='h1000. Then RUN with pc_out 'h1000, 'h1004, 'h1008 on consecutive cycles.
- pc_ready=0 for 3 cycles at pc 'h1008 -> pc_out holds 'h1008. Repeat with stall_in=1 instead -> same result. Release -> 'h100C.
- In the same cycle at pc 'h100C, raise redirect_valid_in(target 'h2000) and trap_in -> next pc 'h100, misalign_err_out=0. Redirect alone to 'h2000 while stall_in=1 -> next pc 'h2000.
- Redirect to 'h2002 with COMPRESSED_EN=0 -> pc 'h100, misalign_err_out=1 for exactly one cycle. Same redirect with COMPRESSED_EN=1 -> pc 'h2002, no error.
- Redirect to 'hFFFF_FFFF_FFFF_FFFC, then advance -> pc_out 'h0.
- halt_in at pc 'h3000 with pc_ready=1 -> pc 'h3004, state HALT, pc_valid=0. Redirect and trap in HALT are ignored. halt_in and resume_in together -> stays HALT. resume_in alone -> RUN at 'h3004. Assert reset mid-HALT -> pc 'h1000, BOOT.
